// File: rtl/tm1638_bcd_display.sv
// tm1638_bcd_display
// Shows a three-digit BCD value on a TM1638 module. Whenever the value
// differs from the last one sent (and once after reset) a complete write
// frame is serialised: data command 0x40, address command 0xC0 followed by
// 16 display bytes, and a display-control command. Write-only, no key scan.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   bcd_in     [3:0] units, [7:4] tens, [11:8] hundreds
//   tm_stb     TM1638 strobe, active-low
//   tm_clk     TM1638 serial clock, idles high
//   tm_dio     TM1638 data (driven only), idles high
//   busy       high while a frame is being sent
//   frame_done one-cycle pulse when a frame has completed
module tm1638_bcd_display #(
  parameter int         CLK_DIV    = 4,
  parameter logic [2:0] BRIGHTNESS = 3'd7,
  parameter int         STB_GAP    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bcd_in,
  output logic        tm_stb,
  output logic        tm_clk,
  output logic        tm_dio,
  output logic        busy,
  output logic        frame_done
);

  localparam int GAP_CYC = STB_GAP * CLK_DIV;
  localparam int TW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STB_SETUP,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_STB_END
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_q, bit_d;
  logic [4:0]      byte_q, byte_d;
  logic [1:0]      cmd_q, cmd_d;
  logic [11:0]     snapshot_q, snapshot_d;
  logic            first_frame_q, first_frame_d;
  logic            tm_stb_q, tm_stb_d;
  logic            tm_clk_q, tm_clk_d;
  logic            tm_dio_q, tm_dio_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic [7:0]      cur_byte;
  logic [4:0]      last_byte;
  logic            timer_done;

  function automatic logic [7:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h40;
    endcase
  endfunction

  // Byte number idx of command cmd. In the address command, byte 0 is the
  // 0xC0 opcode and bytes 1..16 are display addresses 0x00..0x0F; the digits
  // live at the even grid addresses 0x0A/0x0C/0x0E. Leading zeros blank, but
  // a non-decimal nibble compares unequal to zero so it is never blanked.
  function automatic logic [7:0] frame_byte(input logic [1:0]  cmd,
                                            input logic [4:0]  idx,
                                            input logic [11:0] snap);
    logic [7:0] h_seg;
    logic [7:0] t_seg;
    logic [7:0] u_seg;
    h_seg = (snap[11:8] == 4'd0) ? 8'h00 : seg7(snap[11:8]);
    t_seg = ((snap[11:8] == 4'd0) && (snap[7:4] == 4'd0)) ? 8'h00 : seg7(snap[7:4]);
    u_seg = seg7(snap[3:0]);
    frame_byte = 8'h00;
    case (cmd)
      2'd0: frame_byte = 8'h40;
      2'd1: begin
        case (idx)
          5'd0:    frame_byte = 8'hC0;
          5'd11:   frame_byte = h_seg;
          5'd13:   frame_byte = t_seg;
          5'd15:   frame_byte = u_seg;
          default: frame_byte = 8'h00;
        endcase
      end
      default: frame_byte = 8'h88 | {5'b00000, BRIGHTNESS};
    endcase
  endfunction

  // Next-state logic: counters walk bit -> byte -> command; pins are
  // derived from the next state so they are registered alongside it.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    bit_d         = bit_q;
    byte_d        = byte_q;
    cmd_d         = cmd_q;
    snapshot_d    = snapshot_q;
    first_frame_d = first_frame_q;
    frame_done_d  = 1'b0;
    tm_dio_d      = tm_dio_q;
    timer_done    = (timer_q == '0);
    last_byte     = (cmd_q == 2'd1) ? 5'd16 : 5'd0;

    case (state_q)
      S_IDLE: begin
        if (first_frame_q || (bcd_in != snapshot_q)) begin
          snapshot_d = bcd_in;
          state_d    = S_STB_SETUP;
          timer_d    = HALF_LOAD;
          bit_d      = 3'd0;
          byte_d     = 5'd0;
          cmd_d      = 2'd0;
        end
      end
      S_STB_SETUP: begin
        if (timer_done) begin
          state_d = S_BIT_LOW;
          timer_d = HALF_LOAD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_BIT_LOW: begin
        if (timer_done) begin
          state_d = S_BIT_HIGH;
          timer_d = HALF_LOAD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_BIT_HIGH: begin
        if (timer_done) begin
          timer_d = HALF_LOAD;
          if (bit_q != 3'd7) begin
            bit_d   = bit_q + 3'd1;
            state_d = S_BIT_LOW;
          end else if (byte_q != last_byte) begin
            bit_d   = 3'd0;
            byte_d  = byte_q + 5'd1;
            state_d = S_BIT_LOW;
          end else begin
            bit_d   = 3'd0;
            byte_d  = 5'd0;
            state_d = S_STB_END;
            timer_d = GAP_LOAD;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_STB_END: begin
        if (timer_done) begin
          if (cmd_q == 2'd2) begin
            state_d       = S_IDLE;
            cmd_d         = 2'd0;
            frame_done_d  = 1'b1;
            first_frame_d = 1'b0;
          end else begin
            cmd_d   = cmd_q + 2'd1;
            state_d = S_STB_SETUP;
            timer_d = HALF_LOAD;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d != S_IDLE);
    tm_stb_d = !((state_d == S_STB_SETUP) || (state_d == S_BIT_LOW) || (state_d == S_BIT_HIGH));
    tm_clk_d = (state_d != S_BIT_LOW);

    // Data changes only when tm_clk falls, so it is stable at the rising edge.
    cur_byte = frame_byte(cmd_d, byte_d, snapshot_q);
    if ((state_d == S_BIT_LOW) && (state_q != S_BIT_LOW)) begin
      tm_dio_d = cur_byte[bit_d];
    end else if (state_d == S_STB_END) begin
      tm_dio_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      bit_q         <= 3'd0;
      byte_q        <= 5'd0;
      cmd_q         <= 2'd0;
      snapshot_q    <= 12'h000;
      first_frame_q <= 1'b1;
      tm_stb_q      <= 1'b1;
      tm_clk_q      <= 1'b1;
      tm_dio_q      <= 1'b1;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      bit_q         <= bit_d;
      byte_q        <= byte_d;
      cmd_q         <= cmd_d;
      snapshot_q    <= snapshot_d;
      first_frame_q <= first_frame_d;
      tm_stb_q      <= tm_stb_d;
      tm_clk_q      <= tm_clk_d;
      tm_dio_q      <= tm_dio_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign tm_stb     = tm_stb_q;
  assign tm_clk     = tm_clk_q;
  assign tm_dio     = tm_dio_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tm1638_bcd_display.sv
// tb_tm1638_bcd_display
// Drives two instances of tm1638_bcd_display (default timing, and
// CLK_DIV=1/STB_GAP=1), decodes the TM1638 pin activity back into command
// bytes and compares each completed frame against expectations queued when
// the stimulus was applied.
module tb_tm1638_bcd_display;

  typedef struct {
    logic [11:0] bcd;
    logic [7:0]  h;
    logic [7:0]  t;
    logic [7:0]  u;
  } vec_t;

  typedef struct {
    logic [7:0] h;
    logic [7:0] t;
    logic [7:0] u;
    logic [7:0] c3;
    int         busy_len;
    int         half;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [11:0] bcd_a, bcd_b;
  logic        stb_a, sclk_a, dio_a, busy_a, done_a;
  logic        stb_b, sclk_b, dio_b, busy_b, done_b;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   sel = 1'b0;
  exp_t exp_q[$];
  vec_t vecs[7];

  // Pin monitor state
  logic [7:0] mon_bytes[$];
  int         mon_cmdlen[$];
  logic [7:0] mon_cur;
  int         mon_nbits, mon_last, mon_cyc, mon_busy, mon_first_busy;
  int         mon_pin_bad, mon_low_run, mon_low_max;
  bit         mon_done, mon_done_busy, mon_timeout;
  logic       prev_s, prev_c;

  always #5 clk = ~clk;

  tm1638_bcd_display #(.CLK_DIV(4), .BRIGHTNESS(3'd7), .STB_GAP(2)) dut_a (
    .clk(clk), .rst(rst_a), .bcd_in(bcd_a), .tm_stb(stb_a), .tm_clk(sclk_a),
    .tm_dio(dio_a), .busy(busy_a), .frame_done(done_a));

  tm1638_bcd_display #(.CLK_DIV(1), .BRIGHTNESS(3'd7), .STB_GAP(1)) dut_b (
    .clk(clk), .rst(rst_b), .bcd_in(bcd_b), .tm_stb(stb_b), .tm_clk(sclk_b),
    .tm_dio(dio_b), .busy(busy_b), .frame_done(done_b));

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Sets the selected DUT's input and queues the frame it must produce.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    if (sel) bcd_b = v.bcd;
    else     bcd_a = v.bcd;
    e.h        = v.h;
    e.t        = v.t;
    e.u        = v.u;
    e.c3       = 8'h8F;
    e.busy_len = sel ? 310 : 1252;
    e.half     = sel ? 1 : 4;
    exp_q.push_back(e);
  endtask

  task automatic monitorReset();
    mon_bytes.delete();
    mon_cmdlen.delete();
    mon_cur        = 8'h00;
    mon_nbits      = 0;
    mon_last       = 0;
    mon_cyc        = 0;
    mon_busy       = 0;
    mon_first_busy = 0;
    mon_pin_bad    = 0;
    mon_low_run    = 0;
    mon_low_max    = 0;
    mon_done       = 1'b0;
    mon_done_busy  = 1'b0;
    mon_timeout    = 1'b0;
    prev_s         = 1'b1;
    prev_c         = 1'b1;
  endtask

  task automatic sampleMonitor();
    logic s, c, d, b, f;
    s = sel ? stb_b  : stb_a;
    c = sel ? sclk_b : sclk_a;
    d = sel ? dio_b  : dio_a;
    b = sel ? busy_b : busy_a;
    f = sel ? done_b : done_a;
    if (b) begin
      mon_busy++;
      if (mon_first_busy == 0) mon_first_busy = mon_cyc;
    end
    if (s && (!c || !d)) mon_pin_bad++;
    if (!c) mon_low_run++;
    else begin
      if (mon_low_run > mon_low_max) mon_low_max = mon_low_run;
      mon_low_run = 0;
    end
    if (!s && c && !prev_c) begin
      mon_cur[mon_nbits % 8] = d;
      mon_nbits++;
      if ((mon_nbits % 8) == 0) mon_bytes.push_back(mon_cur);
    end
    if (s && !prev_s) begin
      if ((mon_nbits % 8) != 0) mon_pin_bad++;
      mon_cmdlen.push_back(mon_bytes.size() - mon_last);
      mon_last = mon_bytes.size();
    end
    if (f && !mon_done) begin
      mon_done      = 1'b1;
      mon_done_busy = b;
    end
    prev_s = s;
    prev_c = c;
  endtask

  // Advances until frame_done, a requested stop cycle, or the cycle limit.
  task automatic runCycles(input int stop_at, input int limit);
    while (!mon_done && !((stop_at > 0) && (mon_cyc >= stop_at)) && (mon_cyc < limit)) begin
      @(negedge clk);
      mon_cyc++;
      sampleMonitor();
    end
    if (!mon_done && (stop_at == 0) && (mon_cyc >= limit)) mon_timeout = 1'b1;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    int   others;
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, " timeout"}, int'(mon_timeout), 0);
    check({tag, " frame_done"}, int'(mon_done), 1);
    check({tag, " busy_at_done"}, int'(mon_done_busy), 0);
    check({tag, " cmd_count"}, mon_cmdlen.size(), 3);
    if (mon_cmdlen.size() == 3) begin
      check({tag, " c1_len"}, mon_cmdlen[0], 1);
      check({tag, " c2_len"}, mon_cmdlen[1], 17);
      check({tag, " c3_len"}, mon_cmdlen[2], 1);
    end
    check({tag, " byte_count"}, mon_bytes.size(), 19);
    if (mon_bytes.size() == 19) begin
      others = 0;
      for (int i = 2; i < 18; i++)
        if ((i != 12) && (i != 14) && (i != 16) && (mon_bytes[i] != 8'h00)) others++;
      check({tag, " c1_byte"}, int'(mon_bytes[0]), 8'h40);
      check({tag, " c2_byte"}, int'(mon_bytes[1]), 8'hC0);
      check({tag, " hundreds"}, int'(mon_bytes[12]), int'(e.h));
      check({tag, " tens"}, int'(mon_bytes[14]), int'(e.t));
      check({tag, " units"}, int'(mon_bytes[16]), int'(e.u));
      check({tag, " other_addr_nonzero"}, others, 0);
      check({tag, " c3_byte"}, int'(mon_bytes[18]), int'(e.c3));
    end
    check({tag, " busy_len"}, mon_busy, e.busy_len);
    check({tag, " clk_low_half"}, mon_low_max, e.half);
    check({tag, " idle_pin_violation"}, mon_pin_bad, 0);
  endtask

  task automatic checkIdlePins(input string tag);
    check({tag, " tm_stb"}, int'(sel ? stb_b : stb_a), 1);
    check({tag, " tm_clk"}, int'(sel ? sclk_b : sclk_a), 1);
    check({tag, " tm_dio"}, int'(sel ? dio_b : dio_a), 1);
    check({tag, " busy"}, int'(sel ? busy_b : busy_a), 0);
    check({tag, " frame_done"}, int'(sel ? done_b : done_a), 0);
  endtask

  initial begin
    vecs[0] = '{12'h123, 8'h06, 8'h5B, 8'h4F};
    vecs[1] = '{12'h007, 8'h00, 8'h00, 8'h07};
    vecs[2] = '{12'h0A5, 8'h00, 8'h40, 8'h6D};
    vecs[3] = '{12'h908, 8'h6F, 8'h3F, 8'h7F};
    vecs[4] = '{12'h0F0, 8'h00, 8'h40, 8'h3F};
    vecs[5] = '{12'hB00, 8'h40, 8'h3F, 8'h3F};
    vecs[6] = '{12'h050, 8'h00, 8'h6D, 8'h3F};

    rst_a = 1'b1;
    rst_b = 1'b1;
    bcd_a = 12'h000;
    bcd_b = 12'h999;
    sel   = 1'b0;
    repeat (3) @(negedge clk);
    checkIdlePins("reset_a");

    // First frame after reset shows "0"
    applyStimulus('{12'h000, 8'h00, 8'h00, 8'h3F});
    monitorReset();
    rst_a = 1'b0;
    runCycles(0, 4000);
    check("reset_frame busy_latency", mon_first_busy, 1);
    checkOutput("reset_frame");
    @(negedge clk);
    check("reset_frame done_low_after", int'(done_a), 0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      monitorReset();
      runCycles(0, 4000);
      check($sformatf("vec%0d busy_latency", i), mon_first_busy, 1);
      checkOutput($sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d done_low_after", i), int'(done_a), 0);
      check($sformatf("vec%0d idle_after", i), int'(busy_a), 0);
    end

    // Input change in the middle of a frame
    applyStimulus(vecs[0]);
    monitorReset();
    runCycles(300, 4000);
    applyStimulus('{12'h456, 8'h66, 8'h6D, 8'h7D});
    runCycles(0, 4000);
    checkOutput("change_first");
    @(negedge clk);
    check("change done_low_after", int'(done_a), 0);
    check("change back_to_back_busy", int'(busy_a), 1);
    monitorReset();
    mon_busy = 1;
    runCycles(0, 4000);
    checkOutput("change_second");
    monitorReset();
    runCycles(2000, 4000);
    check("no_third_frame busy", mon_busy, 0);
    check("no_third_frame done", int'(mon_done), 0);

    // Reset in the middle of a frame
    bcd_a = 12'h321;
    monitorReset();
    runCycles(600, 4000);
    check("abort no_done_before", int'(mon_done), 0);
    check("abort busy_before", int'(busy_a), 1);
    rst_a = 1'b1;
    @(negedge clk);
    checkIdlePins("abort_reset");
    repeat (2) @(negedge clk);
    applyStimulus('{12'h321, 8'h4F, 8'h5B, 8'h06});
    monitorReset();
    rst_a = 1'b0;
    runCycles(0, 4000);
    check("abort_recover busy_latency", mon_first_busy, 1);
    checkOutput("abort_recover");

    // Fast timing instance
    sel = 1'b1;
    checkIdlePins("reset_b");
    applyStimulus('{12'h999, 8'h6F, 8'h6F, 8'h6F});
    monitorReset();
    rst_b = 1'b0;
    runCycles(0, 2000);
    check("fast busy_latency", mon_first_busy, 1);
    checkOutput("fast");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
